// File: rtl/bin_window_3x3.sv
// 3x3 binary neighbourhood builder for a 1-bit raster stream.
// Define BIN_WIN_COORD_EN to add the win_x/win_y centre-coordinate outputs.
module bin_window_3x3 #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int XW    = 10,
    parameter int YW    = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          in_sof,
    input  logic          in_bit,
    output logic          win_valid,
    output logic [8:0]    win,
    output logic          frame_done,
    output logic          ovf_err
`ifdef BIN_WIN_COORD_EN
    ,
    output logic [XW-1:0] win_x,
    output logic [YW-1:0] win_y
`endif
);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [XW-1:0] X_TWO  = XW'(2);
    localparam logic [YW-1:0] Y_TWO  = YW'(2);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    logic          acc;
    logic          emit;
    logic          end_line;
    logic          last_px;
    logic          up1;
    logic          up2;
    logic [2:0]    r0, r1, r2;
    logic [2:0]    n0, n1, n2;

    logic lb0 [IMG_W];
    logic lb1 [IMG_W];

    // in_sof always restarts the frame at (0,0), whatever state we are in
    always_comb begin
        acc      = in_valid && (in_sof || state == RUN);
        px       = in_sof ? '0 : x;
        py       = in_sof ? '0 : y;
        end_line = (px == X_LAST);
        last_px  = end_line && (py == Y_LAST);
        emit     = acc && (px >= X_TWO) && (py >= Y_TWO);
        up1      = lb0[px];
        up2      = lb1[px];
        n0       = {r0[1:0], up2};
        n1       = {r1[1:0], up1};
        n2       = {r2[1:0], in_bit};
    end

    // Line buffers are plain RAM: read-before-write, never reset
    always_ff @(posedge clk) begin
        if (acc) begin
            lb1[px] <= lb0[px];
            lb0[px] <= in_bit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            r0         <= '0;
            r1         <= '0;
            r2         <= '0;
            win_valid  <= 1'b0;
            win        <= '0;
            frame_done <= 1'b0;
            ovf_err    <= 1'b0;
`ifdef BIN_WIN_COORD_EN
            win_x      <= '0;
            win_y      <= '0;
`endif
        end else begin
            win_valid  <= emit;
            frame_done <= acc && last_px;
            ovf_err    <= in_valid && !in_sof && (state == DONE);
            if (acc) begin
                r0 <= n0;
                r1 <= n1;
                r2 <= n2;
                if (emit) begin
                    win <= {n0, n1, n2};
`ifdef BIN_WIN_COORD_EN
                    win_x <= px - XW'(1);
                    win_y <= py - YW'(1);
`endif
                end
                if (last_px) begin
                    state <= DONE;
                    x     <= '0;
                    y     <= '0;
                end else if (end_line) begin
                    state <= RUN;
                    x     <= '0;
                    y     <= py + YW'(1);
                end else begin
                    state <= RUN;
                    x     <= px + XW'(1);
                    y     <= py;
                end
            end
        end
    end

endmodule
